// File: rtl/fp32_div_ctrl.sv
// Sequential control, unpack and pack wrapper around an external combinational
// mantissa divider for IEEE-754 single-precision division.
module fp32_div_ctrl #(
  parameter int unsigned DIV_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [22:0] div_dividend,
  output logic [22:0] div_divisor,
  input  logic [23:0] div_quotient,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        invalid,
  output logic        div_by_zero,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLASSIFY = 3'd1,
    S_WAIT     = 3'd2,
    S_PACK     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] ra, rb;
  logic        sign, adj;
  logic        spec;
  logic [31:0] spec_res;
  logic        spec_inv, spec_dbz;
  logic [3:0]  cnt;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic        c_spec, c_inv, c_dbz, c_sign;
  logic [31:0] c_res;
  logic signed [9:0] e_calc;
  logic        quot_msb_unused;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign quot_msb_unused = div_quotient[23];

  assign ea = ra[30:23];
  assign eb = rb[30:23];
  assign fa = ra[22:0];
  assign fb = rb[22:0];

  // Exponent 0 covers denormals too: they are flushed to signed zero.
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == '0);
  assign b_inf  = (eb == 8'hFF) && (fb == '0);
  assign a_nan  = (ea == 8'hFF) && (fa != '0);
  assign b_nan  = (eb == 8'hFF) && (fb != '0);
  assign c_sign = ra[31] ^ rb[31];

  always_comb begin
    c_spec = 1'b1;
    c_inv  = 1'b0;
    c_dbz  = 1'b0;
    c_res  = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      c_res = 32'h7FC00000;
      c_inv = 1'b1;
    end else if (a_inf) begin
      c_res = {c_sign, 8'hFF, 23'd0};
    end else if (b_zero) begin
      c_res = {c_sign, 8'hFF, 23'd0};
      c_dbz = 1'b1;
    end else if (a_zero || b_inf) begin
      c_res = {c_sign, 31'd0};
    end else begin
      c_spec = 1'b0;
    end
  end

  assign e_calc = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127
                - $signed({9'd0, adj});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ra           <= '0;
      rb           <= '0;
      sign         <= 1'b0;
      adj          <= 1'b0;
      spec         <= 1'b0;
      spec_res     <= '0;
      spec_inv     <= 1'b0;
      spec_dbz     <= 1'b0;
      cnt          <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      result       <= '0;
      invalid      <= 1'b0;
      div_by_zero  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            ra    <= a;
            rb    <= b;
            state <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          sign     <= c_sign;
          adj      <= (fa < fb);
          spec     <= c_spec;
          spec_res <= c_res;
          spec_inv <= c_inv;
          spec_dbz <= c_dbz;
          // Divider inputs only move for ops that actually use the divider.
          if (c_spec) begin
            state <= S_PACK;
          end else begin
            div_dividend <= fa;
            div_divisor  <= fb;
            cnt          <= 4'(DIV_LAT - 1);
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_PACK;
          else             cnt   <= cnt - 4'd1;
        end
        S_PACK: begin
          invalid     <= 1'b0;
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
          underflow   <= 1'b0;
          if (spec) begin
            result      <= spec_res;
            invalid     <= spec_inv;
            div_by_zero <= spec_dbz;
          end else if (e_calc >= 10'sd255) begin
            result   <= {sign, 8'hFF, 23'd0};
            overflow <= 1'b1;
          end else if (e_calc <= 10'sd0) begin
            result    <= {sign, 31'd0};
            underflow <= 1'b1;
          end else begin
            result <= {sign, e_calc[7:0], div_quotient[22:0]};
          end
          state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            result      <= '0;
            invalid     <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
